// File: rtl/module_disp_7_seg_monitor_pkg.sv
// Shared 7-segment definitions for the display controller and its bus monitor.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package pkg_disp_7_seg;

  localparam int         NUM_DIGITS  = 4;
  localparam logic [7:0] ANODE_BLANK = 8'hFF;

  localparam logic [6:0] SEG_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURED
  } fsm_state_t;

endpackage

// File: rtl/module_disp_7_seg_monitor_if.sv
// Multiplexed display bus plus the monitor's reassembled-frame outputs.
// The master side drives the anode/segment bus; the slave side is the monitor.
interface module_disp_7_seg_monitor_if;

  logic [7:0]  an;
  logic [7:0]  seg;
  logic [15:0] data_out;
  logic        frame_valid;
  logic        frame_error;
  logic        stale;

  modport master (
    output an,
    output seg,
    input  data_out,
    input  frame_valid,
    input  frame_error,
    input  stale
  );

  modport slave (
    input  an,
    input  seg,
    output data_out,
    output frame_valid,
    output frame_error,
    output stale
  );

endinterface

// File: rtl/module_disp_7_seg_monitor_seg_to_hex.sv
// Inverse of the display font: maps an active-low segment pattern back to its
// nibble; unknown patterns (including all-off) give 0 and raise invalid.
module module_seg_to_hex
  import pkg_disp_7_seg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       invalid
);

  always_comb begin
    hex     = 4'h0;
    invalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_CODE[i]) begin
        hex     = 4'(i);
        invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/module_disp_7_seg_monitor.sv
// Receive-side monitor for the multiplexed 7-segment bus: waits for each anode
// to settle, decodes its digit and reports every completed 4-digit frame.
module module_disp_7_seg_monitor
  import pkg_disp_7_seg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  module_disp_7_seg_monitor_if.slave bus
);

  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SCW-1:0] STABLE_LAST  = SCW'(STABLE_CYCLES);
  localparam logic [TOW-1:0] TIMEOUT_LAST = TOW'(TIMEOUT_CYCLES);

  logic [7:0]                 an_q;
  logic [6:0]                 seg_q;
  fsm_state_t                 state_q, state_d;
  logic [1:0]                 idx_q, idx_d;
  logic [SCW-1:0]             cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]      mask_q, mask_d;
  logic                       err_q, err_d;
  logic [TOW-1:0]             timeout_q, timeout_d;
  logic                       stale_q, stale_d;
  logic [15:0]                data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       ferr_q, ferr_d;

  logic       anode_ok;
  logic [1:0] anode_idx;
  logic [3:0] dec_hex;
  logic       dec_invalid;
  logic       frame_done;

  module_seg_to_hex u_seg_to_hex (
    .seg     (seg_q),
    .hex     (dec_hex),
    .invalid (dec_invalid)
  );

  // Only a single low anode among hex0..hex3 with the upper bank dark counts.
  always_comb begin
    anode_ok  = 1'b0;
    anode_idx = 2'd0;
    if (an_q[7:4] == 4'hF) begin
      case (an_q[3:0])
        4'b1110: begin anode_ok = 1'b1; anode_idx = 2'd0; end
        4'b1101: begin anode_ok = 1'b1; anode_idx = 2'd1; end
        4'b1011: begin anode_ok = 1'b1; anode_idx = 2'd2; end
        4'b0111: begin anode_ok = 1'b1; anode_idx = 2'd3; end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    digits_d   = digits_q;
    mask_d     = mask_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    stale_d    = stale_q;
    data_d     = data_q;
    ferr_d     = ferr_q;
    frame_done = (mask_q == '1);
    valid_d    = frame_done;

    if (frame_done) begin
      data_d    = digits_q;
      ferr_d    = err_q;
      mask_d    = '0;
      err_d     = 1'b0;
      timeout_d = '0;
      stale_d   = 1'b0;
    end else if (timeout_q != TIMEOUT_LAST) begin
      timeout_d = timeout_q + TOW'(1);
      if (timeout_d == TIMEOUT_LAST) begin
        mask_d  = '0;
        err_d   = 1'b0;
        stale_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (anode_ok) begin
          state_d = SETTLE;
          idx_d   = anode_idx;
          cnt_d   = SCW'(1);
        end
      end
      SETTLE: begin
        if (!anode_ok) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (anode_idx != idx_q) begin
          idx_d = anode_idx;
          cnt_d = SCW'(1);
        end else begin
          cnt_d = cnt_q + SCW'(1);
        end
      end
      CAPTURED: begin
        if (!anode_ok) begin
          state_d = IDLE;
        end else if (anode_idx != idx_q) begin
          state_d = SETTLE;
          idx_d   = anode_idx;
          cnt_d   = SCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Sample once per anode dwell, on the cycle the settle count is reached.
    if (state_d == SETTLE && cnt_d == STABLE_LAST) begin
      state_d         = CAPTURED;
      digits_d[idx_d] = dec_hex;
      if (!(stale_d && !stale_q)) begin
        mask_d[idx_d] = 1'b1;
        err_d         = err_d | dec_invalid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_q      <= ANODE_BLANK;
      seg_q     <= 7'h7F;
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      digits_q  <= '0;
      mask_q    <= '0;
      err_q     <= 1'b0;
      timeout_q <= '0;
      stale_q   <= 1'b0;
      data_q    <= 16'h0000;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      an_q      <= bus.an;
      seg_q     <= bus.seg[6:0];
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      stale_q   <= stale_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_error = ferr_q;
  assign bus.stale       = stale_q;

endmodule

// File: tb/tb_module_disp_7_seg_monitor.sv
// Bench for the 7-segment bus monitor: drives digit dwells on the bus and
// predicts frames (value, error flag, arrival cycle) from the display rules.
module tb_module_disp_7_seg_monitor;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 200;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          cyc;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] font [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic [3:0]  m_dig [4];
  logic [3:0]  m_mask;
  logic        m_err;
  logic [15:0] last_data;
  logic        last_err;
  frame_t      exp_q [$];
  frame_t      obs_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  module_disp_7_seg_monitor_if mon_if ();

  module_disp_7_seg_monitor #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (mon_if)
  );

  always @(negedge clk) begin : monitor
    frame_t f;
    if (rst && mon_if.frame_valid) begin
      f.data = mon_if.data_out;
      f.err  = mon_if.frame_error;
      f.cyc  = cyc;
      obs_q.push_back(f);
    end
  end

  function automatic logic [4:0] model_decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++) begin
      if (font[i] == s) return {1'b0, 4'(i)};
    end
    return {1'b1, 4'h0};
  endfunction

  // A digit counts once its anode has been on STABLE bus cycles; the frame
  // appears two edges after the cycle that completes the set of four.
  task automatic model_capture(input int idx, input logic [6:0] code, input int e0);
    logic [4:0] r;
    frame_t     f;
    r = model_decode(code);
    m_dig[idx]  = r[3:0];
    m_mask[idx] = 1'b1;
    m_err       = m_err | r[4];
    if (m_mask == 4'hF) begin
      f.data = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
      f.err  = m_err;
      f.cyc  = e0 + STABLE + 1;
      exp_q.push_back(f);
      m_mask = 4'h0;
      m_err  = 1'b0;
    end
  endtask

  task automatic drive_cycle(input logic [7:0] an, input logic [7:0] seg);
    @(negedge clk);
    mon_if.an  = an;
    mon_if.seg = seg;
  endtask

  task automatic show_digit(input int idx, input logic [6:0] code, input int hold,
                            input logic [6:0] ghost, input int glen);
    logic [7:0] an;
    logic [6:0] cur;
    int         e0;
    an      = 8'hFF;
    an[idx] = 1'b0;
    e0      = 0;
    for (int c = 0; c < glen + hold; c++) begin
      cur = (c < glen) ? ghost : code;
      drive_cycle(an, {1'($urandom_range(0, 1)), cur});
      if (c == 0) e0 = cyc + 1;
      if (c == STABLE - 1) model_capture(idx, cur, e0);
    end
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) drive_cycle(8'hFF, 8'($urandom));
  endtask

  task automatic show_word(input logic [15:0] v, input int hold);
    for (int d = 0; d < 4; d++) show_digit(d, font[v[d*4 +: 4]], hold, 7'h7F, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    mon_if.an  = 8'hFF;
    mon_if.seg = 8'hFF;
    repeat (3) @(negedge clk);
    vectors++;
    if (mon_if.data_out !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_data_out: got %h expected 0000", mon_if.data_out);
    end
    vectors++;
    if (mon_if.frame_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_frame_valid: got %b expected 0", mon_if.frame_valid);
    end
    vectors++;
    if (mon_if.frame_error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_frame_error: got %b expected 0", mon_if.frame_error);
    end
    vectors++;
    if (mon_if.stale !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_stale: got %b expected 0", mon_if.stale);
    end
    rst = 1'b1;
    for (int d = 0; d < 4; d++) m_dig[d] = 4'h0;
    m_mask    = 4'h0;
    m_err     = 1'b0;
    last_data = 16'h0000;
    last_err  = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_frames(input string tag);
    int n;
    blank(STABLE + 6);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("[TB] FAIL %s frame_count: got %0d expected %0d", tag, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (obs_q[i].data !== exp_q[i].data) begin
        miscompares++;
        $display("[TB] FAIL %s frame%0d data_out: got %h expected %h", tag, i, obs_q[i].data, exp_q[i].data);
      end
      vectors++;
      if (obs_q[i].err !== exp_q[i].err) begin
        miscompares++;
        $display("[TB] FAIL %s frame%0d frame_error: got %b expected %b", tag, i, obs_q[i].err, exp_q[i].err);
      end
      vectors++;
      if (obs_q[i].cyc != exp_q[i].cyc) begin
        miscompares++;
        $display("[TB] FAIL %s frame%0d arrival_cycle: got %0d expected %0d", tag, i, obs_q[i].cyc, exp_q[i].cyc);
      end
    end
    if (exp_q.size() > 0) begin
      last_data = exp_q[exp_q.size() - 1].data;
      last_err  = exp_q[exp_q.size() - 1].err;
    end
    vectors++;
    if (mon_if.data_out !== last_data) begin
      miscompares++;
      $display("[TB] FAIL %s held_data_out: got %h expected %h", tag, mon_if.data_out, last_data);
    end
    vectors++;
    if (mon_if.frame_error !== last_err) begin
      miscompares++;
      $display("[TB] FAIL %s held_frame_error: got %b expected %b", tag, mon_if.frame_error, last_err);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_loopback();
    logic [15:0] v;
    logic [6:0]  prev;
    v    = 16'hA5C3;
    prev = 7'h7F;
    for (int s = 0; s < 3; s++) begin
      for (int d = 0; d < 4; d++) begin
        show_digit(d, font[v[d*4 +: 4]], 8, prev, (s == 0 && d == 0) ? 0 : 1);
        prev = font[v[d*4 +: 4]];
      end
    end
    check_frames("loopback");
  endtask

  task automatic test_ghosting();
    show_digit(0, font[1], 6, font[8], 2);
    show_digit(1, font[2], 6, font[1], 1);
    show_digit(2, font[3], 6, font[2], 1);
    show_digit(3, font[4], 6, font[3], 1);
    check_frames("ghosting");
    vectors++;
    if (mon_if.data_out[3:0] !== 4'h1) begin
      miscompares++;
      $display("[TB] FAIL ghost_hex0: got %h expected 1", mon_if.data_out[3:0]);
    end
  endtask

  task automatic test_invalid_pattern();
    show_digit(0, font[1], 6, 7'h7F, 0);
    show_digit(1, font[2], 6, 7'h7F, 0);
    show_digit(2, 7'h7F,   6, 7'h7F, 0);
    show_digit(3, font[4], 6, 7'h7F, 0);
    check_frames("invalid_pattern");
    show_word(16'h4321, 6);
    check_frames("clean_after_invalid");
  endtask

  task automatic test_illegal_anodes();
    show_digit(0, font[5], 6, 7'h7F, 0);
    show_digit(1, font[6], 6, 7'h7F, 0);
    for (int i = 0; i < 6; i++) drive_cycle(8'hFC, {1'b1, font[9]});
    for (int i = 0; i < 6; i++) drive_cycle(8'hEF, {1'b1, font[7]});
    for (int i = 0; i < 6; i++) drive_cycle(8'hEE, {1'b1, font[3]});
    check_frames("illegal_anodes");
    show_digit(2, font[7], 6, 7'h7F, 0);
    show_digit(3, font[8], 6, 7'h7F, 0);
    check_frames("after_illegal");
  endtask

  task automatic test_timeout();
    do_reset();
    show_word(16'h5A5A, 6);
    check_frames("pre_timeout");
    show_digit(0, font[9], 6, 7'h7F, 0);
    show_digit(1, font[8], 6, 7'h7F, 0);
    show_digit(2, font[7], 6, 7'h7F, 0);
    blank(TIMEOUT);
    m_mask = 4'h0;
    m_err  = 1'b0;
    vectors++;
    if (mon_if.stale !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_stale: got %b expected 1", mon_if.stale);
    end
    vectors++;
    if (mon_if.data_out !== 16'h5A5A) begin
      miscompares++;
      $display("[TB] FAIL timeout_data_out: got %h expected 5a5a", mon_if.data_out);
    end
    show_digit(3, font[6], 6, 7'h7F, 0);
    check_frames("partial_discarded");
    show_digit(3, font[1], 6, 7'h7F, 0);
    show_digit(2, font[2], 6, 7'h7F, 0);
    show_digit(1, font[3], 6, 7'h7F, 0);
    show_digit(0, font[4], 6, 7'h7F, 0);
    check_frames("after_timeout");
    vectors++;
    if (mon_if.stale !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stale_cleared: got %b expected 0", mon_if.stale);
    end
  endtask

  task automatic test_reset_midframe();
    show_digit(0, font[1], 6, 7'h7F, 0);
    show_digit(1, font[2], 6, 7'h7F, 0);
    show_digit(2, font[3], 6, 7'h7F, 0);
    do_reset();
    show_digit(3, font[4'hB], 6, 7'h7F, 0);
    show_digit(0, font[4'hF], 6, 7'h7F, 0);
    show_digit(1, font[4'hE], 6, 7'h7F, 0);
    show_digit(2, font[4'hE], 6, 7'h7F, 0);
    check_frames("reset_midframe");
  endtask

  task automatic test_random();
    int         order [4];
    int         j, tmp;
    logic [6:0] code;
    do_reset();
    for (int f = 0; f < 12; f++) begin
      for (int d = 0; d < 4; d++) order[d] = d;
      for (int d = 3; d > 0; d--) begin
        j        = int'($urandom_range(0, d));
        tmp      = order[d];
        order[d] = order[j];
        order[j] = tmp;
      end
      if ($urandom_range(0, 2) == 0) begin
        show_digit(order[0], 7'($urandom), STABLE + 1, 7'h7F, 0);
        blank(1);
      end
      for (int d = 0; d < 4; d++) begin
        code = ($urandom_range(0, 5) == 0) ? 7'($urandom) : font[$urandom_range(0, 15)];
        show_digit(order[d], code, STABLE + int'($urandom_range(0, 4)), 7'($urandom),
                   int'($urandom_range(0, STABLE - 1)));
        if ($urandom_range(0, 2) == 0) blank(int'($urandom_range(1, 2)));
      end
      blank(1);
    end
    check_frames("random");
  endtask

  initial begin
    mon_if.an  = 8'hFF;
    mon_if.seg = 8'hFF;
    test_reset();
    test_loopback();
    test_ghosting();
    test_invalid_pattern();
    test_illegal_anodes();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
